puf_crp_controller: RTL

//  Sequences one arbiter-PUF challenge-response evaluation, sitting between

---
 rtl/puf_crp_if.sv | 32 +++
 rtl/puf_crp_controller.sv | 98 +++++++++
 2 files changed

// File: rtl/puf_crp_if.sv
// Signal bundle between host logic, the arbiter-PUF delay line and the CRP controller.
// The controller uses the slave modport; the host side and delay line use master.
interface puf_crp_if #(
  parameter int C_LENGTH   = 8,
  parameter int VOTE_COUNT = 7
);
  localparam int CNT_W = $clog2(VOTE_COUNT + 1);

  logic                start_i;
  logic                abort_i;
  logic [C_LENGTH-1:0] challenge_i;
  logic                busy_o;
  logic                resp_valid_o;
  logic                resp_o;
  logic [CNT_W-1:0]    resp_ones_o;
  logic                stable_o;
  logic [C_LENGTH-1:0] puf_challenge_o;
  logic                puf_pulse_o;
  logic                puf_response_i;

  modport slave (
    input  start_i, abort_i, challenge_i, puf_response_i,
    output busy_o, resp_valid_o, resp_o, resp_ones_o, stable_o,
           puf_challenge_o, puf_pulse_o
  );

  modport master (
    output start_i, abort_i, challenge_i, puf_response_i,
    input  busy_o, resp_valid_o, resp_o, resp_ones_o, stable_o,
           puf_challenge_o, puf_pulse_o
  );
endinterface

// File: rtl/puf_crp_controller.sv
// Arbiter-PUF challenge-response sequencer: latches a challenge, fires VOTE_COUNT
// registered race pulses, samples the synchronised arbiter output and majority-votes.
module puf_crp_controller #(
  parameter int C_LENGTH      = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTE_COUNT    = 7
) (
  input  logic      clk,
  input  logic      rst_n,
  puf_crp_if.slave  bus
);
  localparam int CNT_W = $clog2(VOTE_COUNT + 1);
  localparam int PH_W  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIRE, S_SETTLE, S_SAMPLE, S_CLEAR, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PH_W-1:0]     r_phase_cnt;
  logic [CNT_W-1:0]    r_ones;
  logic [CNT_W-1:0]    r_races;
  logic [1:0]          r_sync;
  logic [C_LENGTH-1:0] r_challenge;
  logic                r_pulse;
  logic                r_resp_valid;
  logic                r_resp;
  logic [CNT_W-1:0]    r_resp_ones;
  logic                r_stable;
  logic                w_phase_done;

  assign w_phase_done = (r_phase_cnt == PH_W'(SETTLE_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start_i && !bus.abort_i) w_next = S_LOAD;
      S_LOAD:   w_next = S_FIRE;
      S_FIRE:   w_next = S_SETTLE;
      S_SETTLE: if (w_phase_done) w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_CLEAR;
      S_CLEAR:  if (w_phase_done) w_next = (r_races == CNT_W'(VOTE_COUNT)) ? S_DONE : S_FIRE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && bus.abort_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_phase_cnt  <= '0;
      r_ones       <= '0;
      r_races      <= '0;
      r_sync       <= '0;
      r_challenge  <= '0;
      r_pulse      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp       <= 1'b0;
      r_resp_ones  <= '0;
      r_stable     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[0], bus.puf_response_i};
      // Phase counter only runs while dwelling in SETTLE or CLEAR.
      if (w_next == r_state && (r_state == S_SETTLE || r_state == S_CLEAR))
        r_phase_cnt <= r_phase_cnt + 1'b1;
      else
        r_phase_cnt <= '0;
      // Outputs are decoded from the next state so they leave a flop, glitch-free.
      r_pulse      <= (w_next == S_FIRE) || (w_next == S_SETTLE);
      r_resp_valid <= (w_next == S_DONE);
      if (r_state == S_IDLE && w_next == S_LOAD) begin
        r_challenge <= bus.challenge_i;
        r_ones      <= '0;
        r_races     <= '0;
      end
      if (r_state == S_SAMPLE) begin
        r_ones  <= r_ones + CNT_W'(r_sync[1]);
        r_races <= r_races + 1'b1;
      end
      if (w_next == S_DONE) begin
        r_resp      <= (r_ones > CNT_W'(VOTE_COUNT / 2));
        r_resp_ones <= r_ones;
        r_stable    <= (r_ones == '0) || (r_ones == CNT_W'(VOTE_COUNT));
      end
    end
  end

  assign bus.busy_o          = (r_state != S_IDLE);
  assign bus.resp_valid_o    = r_resp_valid;
  assign bus.resp_o          = r_resp;
  assign bus.resp_ones_o     = r_resp_ones;
  assign bus.stable_o        = r_stable;
  assign bus.puf_challenge_o = r_challenge;
  assign bus.puf_pulse_o     = r_pulse;
endmodule
